uart_cmd_parser: RTL and testbench

Receive-side frame decoder for the host UART link: consumes the byte stream from the UART receiver (`rx_data`/`rx_en`) and recovers fixed-format command frames from the host. For each good frame it presents the command byte and payload as a one-cycle strobe with held fields, for the camera/HDMI control logic. It validates the header, length and checksum, and recovers from line noise and truncated frames via an inter-byte timeout. Single clock domain, same clock as the UART receiver.

---
 rtl/uart_cmd_pkg.sv | 29 ++
 rtl/uart_byte_timeout.sv | 36 +++
 rtl/uart_cmd_parser.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the host UART command parser: frame header bytes,
// parser state encoding, error codes and a saturating counter helper.
// No ports (package).
package uart_cmd_pkg;

    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hAA;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_HDR2 = 3'd1,
        ST_CMD  = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CHK  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// uart_byte_timeout
// Inter-byte idle counter. Counts clocks while enabled and no byte arrives;
// pulses expire on the cycle whose clock edge brings the count to TIMEOUT_CYC.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   enable     : counting allowed (parser is inside a frame)
//   clear      : byte arrived this cycle; restarts the count and wins over expiry
//   expire     : one-cycle expiry indication (combinational, registered by user)
module uart_byte_timeout #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);
    localparam logic [15:0] LAST  = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Asserted while the count is one short of the limit, so the consumer's
    // register and the counter reach their final values on the same edge.
    assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Recovers 55 AA CMD LEN payload CHK command frames from the UART receiver
// byte stream and presents good frames as a one-cycle strobe with held fields.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   rx_data      : received byte, valid while rx_en is high
//   rx_en        : one-cycle byte-valid pulse
//   cmd_valid    : one-cycle pulse, good frame accepted
//   cmd_id       : command byte of the last good frame
//   cmd_len      : payload length of the last good frame
//   cmd_payload  : payload of the last good frame, byte 0 in [7:0], unused zero
//   frame_err    : one-cycle pulse, frame rejected
//   err_code     : reason for the most recent rejection (held)
//   ok_cnt       : saturating good-frame count
//   err_cnt      : saturating rejected-frame count
//   state        : current parser state (observation only)
//
// Handshake: rx_en is a valid-only strobe with no ready; every byte presented
// with rx_en=1 is consumed in that cycle, there is no back-pressure.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN     = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_en,
    output logic                   cmd_valid,
    output logic [7:0]             cmd_id,
    output logic [3:0]             cmd_len,
    output logic [8*MAX_LEN-1:0]   cmd_payload,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic [7:0]             ok_cnt,
    output logic [7:0]             err_cnt,
    output state_t                 state
);

    // Shadow copy of the frame in flight; only copied out on a good checksum.
    logic [7:0]           sh_id;
    logic [3:0]           sh_len;
    logic [8*MAX_LEN-1:0] sh_payload;
    logic [7:0]           sum;
    logic [3:0]           idx;

    logic tmo_enable;
    logic tmo_expire;

    // Header hunting is open-ended; only a frame body can time out.
    assign tmo_enable = (state != ST_HUNT) && (state != ST_HDR2);

    uart_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (tmo_enable),
        .clear  (rx_en),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HUNT;
            cmd_valid   <= 1'b0;
            cmd_id      <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            ok_cnt      <= '0;
            err_cnt     <= '0;
            sh_id       <= '0;
            sh_len      <= '0;
            sh_payload  <= '0;
            sum         <= '0;
            idx         <= '0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (rx_en) begin
                unique case (state)
                    ST_HUNT: begin
                        if (rx_data == HDR0) state <= ST_HDR2;
                    end
                    ST_HDR2: begin
                        // A repeated 0x55 may itself be the real first header byte.
                        if (rx_data == HDR1)      state <= ST_CMD;
                        else if (rx_data != HDR0) state <= ST_HUNT;
                    end
                    ST_CMD: begin
                        sh_id      <= rx_data;
                        sum        <= rx_data;
                        sh_payload <= '0;
                        state      <= ST_LEN;
                    end
                    ST_LEN: begin
                        sh_len <= rx_data[3:0];
                        sum    <= sum + rx_data;
                        idx    <= '0;
                        // Full 8-bit compare so e.g. 0x13 is not mistaken for 3.
                        if (rx_data > 8'(MAX_LEN)) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            err_cnt   <= sat_inc(err_cnt);
                            state     <= ST_HUNT;
                        end else if (rx_data == 8'd0) begin
                            state <= ST_CHK;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx == 4'(i)) sh_payload[i*8 +: 8] <= rx_data;
                        end
                        sum <= sum + rx_data;
                        idx <= idx + 4'd1;
                        if (idx == sh_len - 4'd1) state <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (rx_data == sum) begin
                            cmd_valid   <= 1'b1;
                            cmd_id      <= sh_id;
                            cmd_len     <= sh_len;
                            cmd_payload <= sh_payload;
                            ok_cnt      <= sat_inc(ok_cnt);
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                            err_cnt   <= sat_inc(err_cnt);
                        end
                        state <= ST_HUNT;
                    end
                    default: state <= ST_HUNT;
                endcase
            end else if (tmo_expire) begin
                // Expiry is suppressed by the timer whenever a byte is present.
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
                err_cnt   <= sat_inc(err_cnt);
                state     <= ST_HUNT;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Bench for uart_cmd_parser: directed frames plus random byte streams, checked
// against a frame-buffer reference model and an expected-event queue.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int TMO     = 200;
    localparam int W       = 80;  // {kind[1:0], code[1:0], id[7:0], len[3:0], payload[63:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_en = 1'b0;

    logic                 cmd_valid;
    logic [7:0]           cmd_id;
    logic [3:0]           cmd_len;
    logic [8*MAX_LEN-1:0] cmd_payload;
    logic                 frame_err;
    logic [1:0]           err_code;
    logic [7:0]           ok_cnt;
    logic [7:0]           err_cnt;
    state_t               dut_state;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_en       (rx_en),
        .cmd_valid   (cmd_valid),
        .cmd_id      (cmd_id),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .ok_cnt      (ok_cnt),
        .err_cnt     (err_cnt),
        .state       (dut_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   mbuf[$];   // bytes of the frame the model is currently collecting
    logic [7:0]   txq[$];

    int          exp_ok    = 0;
    int          exp_err   = 0;
    logic [7:0]  last_id   = '0;
    logic [3:0]  last_len  = '0;
    logic [63:0] last_pay  = '0;
    logic [1:0]  last_code = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_q.push_back({2'b01, code, 8'h00, 4'h0, 64'h0});
    endtask

    // Reference model: collect a frame as a list of bytes and judge it once
    // the list is long enough to be complete.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0]  s;
        logic [63:0] pay;
        int          n;
        if (mbuf.size() == 0) begin
            if (b == 8'h55) mbuf.push_back(b);
        end else if (mbuf.size() == 1) begin
            if (b == 8'hAA)      mbuf.push_back(b);
            else if (b != 8'h55) mbuf.delete();
        end else begin
            mbuf.push_back(b);
            n = mbuf.size();
            if (n == 4 && int'(mbuf[3]) > MAX_LEN) begin
                push_err(2'b10);
                mbuf.delete();
            end else if (n >= 5 && n == 5 + int'(mbuf[3])) begin
                s = '0;
                for (int i = 2; i < n - 1; i++) s = s + mbuf[i];
                if (s == mbuf[n-1]) begin
                    pay = '0;
                    for (int i = 0; i < int'(mbuf[3]); i++) pay[i*8 +: 8] = mbuf[4+i];
                    exp_q.push_back({2'b10, 2'b00, mbuf[2], mbuf[3][3:0], pay});
                end else begin
                    push_err(2'b01);
                end
                mbuf.delete();
            end
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_ok = 0; exp_err = 0;
                last_id = '0; last_len = '0; last_pay = '0; last_code = '0;
            end else if (cmd_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'({cmd_valid, frame_err}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 64'({cmd_valid, frame_err}), 64'(e[79:78]));
                    if (e[79:78] == 2'b10) begin
                        if (exp_ok < 255) exp_ok++;
                        last_id  = e[75:68];
                        last_len = e[67:64];
                        last_pay = e[63:0];
                    end else begin
                        if (exp_err < 255) exp_err++;
                        last_code = e[77:76];
                    end
                    check("cmd_id",      64'(cmd_id),   64'(last_id));
                    check("cmd_len",     64'(cmd_len),  64'(last_len));
                    check("cmd_payload", cmd_payload,   last_pay);
                    check("err_code",    64'(err_code), 64'(last_code));
                    check("ok_cnt",      64'(ok_cnt),   64'(exp_ok));
                    check("err_cnt",     64'(err_cnt),  64'(exp_err));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note_idle(input int n);
        if (n >= TMO && mbuf.size() >= 2) begin
            push_err(2'b11);
            mbuf.delete();
        end
    endtask

    task automatic idle(input int n);
        note_idle(n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        rx_data = b;
        rx_en   = 1'b1;
        step();
        rx_en   = 1'b0;
    endtask

    task automatic send_txq();
        foreach (txq[i]) send_byte(txq[i]);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        mbuf.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_good(input logic [7:0] id, input int len);
        logic [7:0] s, b;
        txq = '{8'h55, 8'hAA, id, 8'(len)};
        s = id + 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            txq.push_back(b);
            s = s + b;
        end
        txq.push_back(s);
        send_txq();
    endtask

    task automatic send_random_frame();
        logic [7:0] id, len, s, b;
        int gap;
        txq.delete();
        repeat ($urandom_range(0, 2)) txq.push_back(8'($urandom_range(0, 255)));
        id  = 8'($urandom_range(0, 255));
        len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(9, 255))
                                          : 8'($urandom_range(0, MAX_LEN));
        txq.push_back(8'h55);
        txq.push_back(8'hAA);
        txq.push_back(id);
        txq.push_back(len);
        s = id + len;
        if (int'(len) <= MAX_LEN) begin
            for (int i = 0; i < int'(len); i++) begin
                b = 8'($urandom_range(0, 255));
                txq.push_back(b);
                s = s + b;
            end
            txq.push_back(($urandom_range(0, 4) == 0) ? (s ^ 8'($urandom_range(1, 255))) : s);
        end
        foreach (txq[i]) begin
            gap = $urandom_range(0, 2);
            if (mbuf.size() != 1 && $urandom_range(0, 59) == 0) gap = $urandom_range(TMO - 1, TMO);
            idle(gap);
            send_byte(txq[i]);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        fork
            monitor();
        join_none

        step();
        step();
        check("rst_cmd_valid", 64'(cmd_valid),  64'd0);
        check("rst_frame_err", 64'(frame_err),  64'd0);
        check("rst_cmd_id",    64'(cmd_id),     64'd0);
        check("rst_cmd_len",   64'(cmd_len),    64'd0);
        check("rst_payload",   cmd_payload,     64'd0);
        check("rst_err_code",  64'(err_code),   64'd0);
        check("rst_ok_cnt",    64'(ok_cnt),     64'd0);
        check("rst_err_cnt",   64'(err_cnt),    64'd0);
        check("rst_state",     64'(dut_state),  64'(ST_HUNT));
        reset = 1'b0;
        step();

        // Basic good frame
        txq = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
        send_txq();
        idle(2);
        check("good_id",      64'(cmd_id),  64'h10);
        check("good_len",     64'(cmd_len), 64'd3);
        check("good_payload", cmd_payload,  64'h030201);
        check("good_ok_cnt",  64'(ok_cnt),  64'd1);

        // Same frame, bad checksum: fields keep the previous good frame
        txq = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h04, 8'h05, 8'h06, 8'h18};
        send_txq();
        idle(2);
        check("badchk_code",    64'(err_code), 64'd1);
        check("badchk_err_cnt", 64'(err_cnt),  64'd1);
        check("badchk_payload", cmd_payload,   64'h030201);

        // Leading garbage and a repeated 0x55, zero-length payload
        txq = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h20, 8'h00, 8'h20};
        send_txq();
        idle(2);
        check("garb_id",      64'(cmd_id),  64'h20);
        check("garb_len",     64'(cmd_len), 64'd0);
        check("garb_payload", cmd_payload,  64'd0);

        // Over-length, then a normal frame right after the CHK of nothing
        txq = '{8'h55, 8'hAA, 8'h11, 8'h09};
        send_txq();
        idle(2);
        check("len_code", 64'(err_code), 64'd2);
        txq = '{8'h55, 8'hAA, 8'h30, 8'h01, 8'h7F, 8'hB0, 8'h55, 8'hAA, 8'h31, 8'h00, 8'h31};
        send_txq();
        idle(2);
        check("after_len_id",  64'(cmd_id), 64'h31);
        check("after_len_ok",  64'(ok_cnt), 64'd4);

        // Timeout exactly at expiry
        txq = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01};
        send_txq();
        note_idle(TMO);
        repeat (TMO - 1) step();
        check("tmo_early", 64'(frame_err), 64'd0);
        step();
        check("tmo_pulse", 64'(frame_err), 64'd1);
        check("tmo_code",  64'(err_code),  64'd3);
        step();

        // Byte on the expiry cycle suppresses the timeout
        txq = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01};
        send_txq();
        idle(TMO - 1);
        txq = '{8'h02, 8'h03, 8'h19};
        send_txq();
        idle(2);
        check("tmo_sup_ok",  64'(ok_cnt),  64'd5);
        check("tmo_sup_err", 64'(err_cnt), 64'd3);

        // Reset mid-DATA, then a good frame
        txq = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02};
        send_txq();
        do_reset();
        check("midrst_ok",  64'(ok_cnt),  64'd0);
        check("midrst_err", 64'(err_cnt), 64'd0);
        txq = '{8'h55, 8'hAA, 8'h44, 8'h02, 8'hAB, 8'hCD, 8'hBE};
        send_txq();
        idle(2);
        check("midrst_id",      64'(cmd_id),  64'h44);
        check("midrst_payload", cmd_payload,  64'hCDAB);
        check("midrst_err2",    64'(err_cnt), 64'd0);

        // Random streams
        for (int n = 0; n < 150; n++) send_random_frame();
        idle(TMO);
        idle(3);

        // Saturation of ok_cnt
        do_reset();
        for (int n = 0; n < 300; n++) send_good(8'($urandom_range(0, 255)), $urandom_range(0, MAX_LEN));
        idle(3);
        check("ok_cnt_sat", 64'(ok_cnt), 64'd255);

        idle(3);
        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
